mux_sel_arbiter_4: RTL and testbench
====================================

Name: mux_sel_arbiter_4

Overview:
- Round-robin arbitration and output-register stage that sits around the 4:1 data mux.
- Chooses one of four requesting sources and drives the mux `sel`.
- Takes the mux result back on `mux_y` in the same cycle and registers it into a valid/ready output stream, tagged with its source index.
- Converts a purely combinational selector into a fair, back-pressurable 4-to-1 stream merge.

Parameters:
- WIDTH, 4, data width of the mux result and of the output register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-source valid; req[i]=1 means d_i at the mux is valid.
- ack  output  4  one-hot per-source accept; ack[i]=1 means d_i is consumed this cycle.
- sel  output  2  mux select, combinational.
- mux_y  input  WIDTH  mux output for the current `sel`, combinational return path.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  WIDTH  registered data.
- out_src  output  2  index of the source that produced out_data.

Behaviour:
- Reset, asynchronous: out_valid=0, out_data=0, out_src=0, last pointer ptr=3. With ptr=3, source 0 has top priority on the first arbitration after reset.
- Reset asserted mid-transfer: the held output is discarded and no ack is issued while rst=1.
- load_en = !out_valid | out_ready. The output slot is free, or is being drained this cycle.
- Grant selection, combinational:
  - Search req starting at (ptr+1) mod 4, wrapping: ptr+1, ptr+2, ptr+3, ptr.
  - The first set bit is the winner w.
  - grant_valid = |req.
- sel output:
  - sel = w when grant_valid.
  - Otherwise sel = ptr, so the mux select does not toggle while idle.
- ack = onehot(w) when grant_valid & load_en & !rst; otherwise 0.
- On a clock edge with grant_valid & load_en:
  - out_data <= mux_y.
  - out_src <= w.
  - out_valid <= 1.
  - ptr <= w.
- On a clock edge with !grant_valid & out_valid & out_ready: out_valid <= 0. out_data and out_src keep their values.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_src stay stable, ack=0, and ptr is unchanged.
- Latency: 1 cycle from ack[i] to out_valid with that data.
- Throughput: 1 transfer/cycle when out_ready is held high. Simultaneous drain and load is legal and keeps out_valid=1.
- Fairness: any source with req held high is granted within 4 grants.
- A source dropping req before ack is allowed. It simply is not selected.
- Only 2-bit index arithmetic is used; wrap-around is natural mod 4.
- State machine, 2 states (encoded by out_valid):
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on a grant with out_ready, or on !out_ready.
  - FULL -> EMPTY on out_ready with no grant.
- `sel` and `ack` depend combinationally on req, ptr, out_valid and out_ready.
- mux_y must depend only on `sel` and the data inputs. It must not depend on ack, so no combinational loop through this block.

Decomposition:
- Package arb_pkg:
  - N_SRC=4 and SRC_W=2 constants.
  - typedef src_idx_t (logic [SRC_W-1:0]).
  - function rr_next(req, ptr) returning winner index and a found flag.
- One combinational sub-module, rr_pick_4: inputs req[3:0] and ptr[1:0]; outputs w[1:0] and grant_valid.
- Top level holds ptr, the output register and the ack/load logic.

Test Plan:
- Reset/priority: assert rst async mid-cycle with out_valid=1 -> out_valid=0 immediately. After release, req=4'b1111 with mux_y following d0..d3={4'h1,4'h2,4'h3,4'h4} and out_ready=1 -> ack sequence 0001, 0010, 0100, 1000, 0001 and out_data sequence 1, 2, 3, 4, 1 on consecutive cycles.
- Skip idle sources: req=4'b1010 with ptr=1 after a grant to source 1 -> next grant source 3, then source 1. sel alternates 3, 1. out_src matches.
- Backpressure: out_ready=0 while out_valid=1 and req=4'b0100 held -> ack=0, out_data stable for 5 cycles. Raise out_ready -> ack[2]=1 the same cycle, and new data appears on the next edge.
- Idle sel hold: last grant to source 2, then req=0 -> sel stays 2. On the drain cycle out_valid falls to 0, then stays 0; out_data is unchanged.
- Single-requester streaming: req=4'b0001 held, out_ready=1, d0 changing 0..F -> 1 transfer/cycle, out_data follows d0 delayed 1 cycle, out_src=0 throughout.
- Random req/out_ready for 10k cycles against a reference model -> no lost or duplicated transfers; every held request is granted within 4 grants; ack is never non-one-hot.

Source files
------------

// File: rtl/mux_sel_arbiter_4_pkg.sv
// rtl/mux_sel_arbiter_4_pkg.sv - shared constants, types and round-robin search for the 4:1 arbiter
package arb_pkg;

  localparam int N_SRC = 4;
  localparam int SRC_W = 2;

  typedef logic [SRC_W-1:0] src_idx_t;

  // Output slot occupancy; FULL means out_data is being offered downstream
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    src_idx_t w;
    logic     found;
  } rr_pick_t;

  // Scan ptr+1, ptr+2, ptr+3, ptr and return the first requester.
  // With no requester the returned index is ptr, so an idle select never moves.
  function automatic rr_pick_t rr_next(input logic [N_SRC-1:0] req, input src_idx_t ptr);
    rr_pick_t r;
    src_idx_t idx;
    r.w     = ptr;
    r.found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = ptr + src_idx_t'(k);
      if (!r.found && req[idx]) begin
        r.w     = idx;
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational round-robin winner search over four requests
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output src_idx_t         w,
  output logic             grant_valid
);

  rr_pick_t pick;

  // Winner search starts one past the last granted source
  always_comb begin
    pick        = rr_next(req, ptr);
    w           = pick.w;
    grant_valid = pick.found;
  end

endmodule

// File: rtl/mux_sel_arbiter_4.sv
// rtl/mux_sel_arbiter_4.sv - round-robin mux select with registered valid/ready output stage
module mux_sel_arbiter_4
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  slot_state_t state;
  src_idx_t    ptr;
  src_idx_t    w;
  logic        grant_valid;
  logic        load_en;

  rr_pick_4 u_pick (
    .req         (req),
    .ptr         (ptr),
    .w           (w),
    .grant_valid (grant_valid)
  );

  // Slot can take new data when empty or when its current word leaves this cycle
  assign load_en   = (state == EMPTY) || out_ready;
  // Idle search returns ptr, so sel holds steady without an extra mux
  assign sel       = w;
  assign out_valid = (state == FULL);

  // One-hot accept of the winner; suppressed during reset so nothing is consumed then
  always_comb begin
    ack = '0;
    if (grant_valid && load_en && !rst) begin
      ack[w] = 1'b1;
    end
  end

  // Output slot FSM, captured data/source tag and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= src_idx_t'(N_SRC - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (grant_valid) begin
            out_data <= mux_y;
            out_src  <= w;
            ptr      <= w;
            state    <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (grant_valid) begin
              out_data <= mux_y;
              out_src  <= w;
              ptr      <= w;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter_4.sv
// tb/tb_mux_sel_arbiter_4.sv - self-checking bench for mux_sel_arbiter_4
module tb_mux_sel_arbiter_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [1:0]   sel;
  logic [W-1:0] mux_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic [W-1:0] d [4];

  int tests = 0;
  int fails = 0;

  // reference state
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_src;
  int waits [4];
  int model_grants;
  int dut_acks;
  logic [3:0] last_ack;
  logic [1:0] last_sel;

  mux_sel_arbiter_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  assign mux_y = d[sel];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 3;
    m_valid = 0;
    m_data  = 0;
    m_src   = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  // first requester at ptr+1, ptr+2, ... (mod 4); -1 when nobody asks
  function automatic int m_winner(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // one clock with the current inputs: check comb outputs mid-cycle, registered outputs after the edge
  task automatic cycle();
    int w;
    bit load;
    logic [3:0] eack;
    @(negedge clk);
    w    = m_winner(req);
    load = !m_valid || out_ready;
    eack = (w >= 0 && load) ? (4'b0001 << w) : 4'b0000;
    last_ack = ack;
    last_sel = sel;
    chk("sel", 32'(sel), (w >= 0) ? 32'(w) : 32'(m_ptr));
    chk("ack", 32'(ack), 32'(eack));
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    if (ack != 0) dut_acks++;
    for (int i = 0; i < 4; i++) begin
      if (!req[i]) waits[i] = 0;
      else if (w >= 0 && load) begin
        if (i == w) waits[i] = 0;
        else waits[i]++;
      end
      if (req[i]) chk("fairness", 32'(waits[i] <= 3), 32'd1);
    end
    if (w >= 0 && load) begin
      m_data  = int'(d[w]);
      m_src   = w;
      m_valid = 1;
      m_ptr   = w;
      model_grants++;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
  endtask

  logic [3:0] rr_ack [5];
  logic [3:0] rr_dat [5];

  initial begin
    rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    model_grants = 0;
    dut_acks     = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_src", 32'(out_src), 32'd0);

    // async reset mid-cycle discards a held word
    d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
    req = 4'b0001;
    cycle();
    chk("prefill_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("rst_no_ack", 32'(ack), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin from source 0 after reset
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_ack", 32'(last_ack), 32'(rr_ack[i]));
      chk("rr_data", 32'(out_data), 32'(rr_dat[i]));
    end

    // idle sources skipped: grant 1, then 3, then 1
    req = 4'b0010;
    cycle();
    req = 4'b1010;
    cycle();
    chk("skip_sel3", 32'(last_sel), 32'd3);
    chk("skip_src3", 32'(out_src), 32'd3);
    cycle();
    chk("skip_sel1", 32'(last_sel), 32'd1);
    chk("skip_src1", 32'(out_src), 32'd1);

    // backpressure holds the slot, release grants the same cycle
    req = 4'b0100;
    cycle();
    out_ready = 1'b0;
    d[2] = 4'h9;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ack", 32'(last_ack), 32'd0);
      chk("bp_data", 32'(out_data), 32'h3);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_ack", 32'(last_ack), 32'b0100);
    chk("bp_release_data", 32'(out_data), 32'h9);

    // idle: sel parks on last grant, slot drains and data is kept
    req = 4'b0000;
    cycle();
    chk("idle_sel", 32'(last_sel), 32'd2);
    chk("idle_drain", 32'(out_valid), 32'd0);
    chk("idle_data", 32'(out_data), 32'h9);
    cycle();
    chk("idle_sel2", 32'(last_sel), 32'd2);
    chk("idle_stay", 32'(out_valid), 32'd0);

    // single requester streams one word per cycle
    req = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      d[0] = 4'(v);
      cycle();
      chk("stream_ack", 32'(last_ack), 32'b0001);
      chk("stream_data", 32'(out_data), 32'(v));
      chk("stream_src", 32'(out_src), 32'd0);
    end

    // random traffic against the reference
    for (int n = 0; n < 10000; n++) begin
      req       = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < 4; i++) d[i] = W'($urandom);
      cycle();
    end
    chk("xfer_count", 32'(dut_acks), 32'(model_grants));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
